// File: rtl/dcache_pkg.sv
// Shared constants, FSM encoding and address-field helpers for the data cache.
package dcache_pkg;

  localparam int unsigned WORDS_PER_LINE    = 4;
  localparam int unsigned OFFSET_WIDTH      = 2;
  localparam int unsigned BYTE_OFFSET_WIDTH = 2;
  localparam int unsigned LINE_LSB          = OFFSET_WIDTH + BYTE_OFFSET_WIDTH;

  typedef logic [1:0] dc_state_t;

  localparam dc_state_t StIdle   = 2'd0;
  localparam dc_state_t StRefill = 2'd1;
  localparam dc_state_t StWrite  = 2'd2;
  localparam dc_state_t StResp   = 2'd3;

  function automatic int unsigned tag_width(input int unsigned addr_w,
                                            input int unsigned index_w);
    return addr_w - index_w - LINE_LSB;
  endfunction

endpackage

// File: rtl/dcache_tagarray.sv
// Valid + tag storage for the direct-mapped cache: combinational hit, synchronous write,
// synchronous valid clear on reset (tags themselves are not reset).
module dcache_tagarray #(
  parameter int unsigned IndexWidth = 4,
  parameter int unsigned TagWidth   = 24
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [IndexWidth-1:0] index_i,
  input  logic [TagWidth-1:0]   tag_i,
  output logic                  hit_o,
  input  logic                  we_i
);

  localparam int unsigned Lines = 1 << IndexWidth;

  logic [Lines-1:0]    valid_q, valid_d;
  logic [TagWidth-1:0] tag_q [Lines];
  logic [TagWidth-1:0] tag_d [Lines];

  assign hit_o = valid_q[index_i] && (tag_q[index_i] == tag_i);

  always_comb begin
    valid_d = valid_q;
    tag_d   = tag_q;
    if (we_i) begin
      valid_d[index_i] = 1'b1;
      tag_d[index_i]   = tag_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      valid_q <= '0;
    end else begin
      valid_q <= valid_d;
    end
  end

  always_ff @(posedge clk_i) begin
    tag_q <= tag_d;
  end

endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-through, no-write-allocate data cache with 4-word lines.
// Define DCACHE_PERF_EN to add load hit/miss counters (o_hit_cnt, o_miss_cnt).
module dcache_ctrl
  import dcache_pkg::*;
#(
  parameter int unsigned ADDR_MEM_WIDTH = 32,
  parameter int unsigned INDEX_WIDTH    = 4
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic                      i_req,
  input  logic                      i_we,
  input  logic [ADDR_MEM_WIDTH-1:0] i_addr,
  input  logic [31:0]               i_data,
  output logic                      o_ack,
  output logic [31:0]               o_data,
  output logic                      o_mem_req,
  output logic                      o_mem_we,
  output logic [ADDR_MEM_WIDTH-1:0] o_mem_addr,
  output logic [31:0]               o_mem_data,
  input  logic                      i_mem_ack,
  input  logic [31:0]               i_mem_data
`ifdef DCACHE_PERF_EN
  ,
  output logic [31:0]               o_hit_cnt,
  output logic [31:0]               o_miss_cnt
`endif
);

  localparam int unsigned Lines    = 1 << INDEX_WIDTH;
  localparam int unsigned TagWidth = tag_width(ADDR_MEM_WIDTH, INDEX_WIDTH);

  logic [TagWidth-1:0]     req_tag;
  logic [INDEX_WIDTH-1:0]  req_index;
  logic [OFFSET_WIDTH-1:0] req_off;
  logic                    hit, tag_we;
  logic                    unused_addr_bits;

  assign req_tag          = i_addr[ADDR_MEM_WIDTH-1 -: TagWidth];
  assign req_index        = i_addr[INDEX_WIDTH+LINE_LSB-1:LINE_LSB];
  assign req_off          = i_addr[LINE_LSB-1:BYTE_OFFSET_WIDTH];
  assign unused_addr_bits = ^i_addr[BYTE_OFFSET_WIDTH-1:0];

  dc_state_t                 state_q, state_d;
  logic [OFFSET_WIDTH-1:0]   beat_q, beat_d;
  logic                      ack_q, ack_d;
  logic [31:0]               rdata_q, rdata_d;
  logic                      mem_req_q, mem_req_d;
  logic                      mem_we_q, mem_we_d;
  logic [ADDR_MEM_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]               mem_data_q, mem_data_d;

  logic [31:0] data_q [Lines][WORDS_PER_LINE];
  logic [31:0] data_d [Lines][WORDS_PER_LINE];
  logic [31:0] fill_q [WORDS_PER_LINE];
  logic [31:0] fill_d [WORDS_PER_LINE];
  logic [31:0] line_fill [WORDS_PER_LINE];

  dcache_tagarray #(
    .IndexWidth(INDEX_WIDTH),
    .TagWidth  (TagWidth)
  ) u_tagarray (
    .clk_i  (i_clk),
    .rst_ni (i_rst_n),
    .index_i(req_index),
    .tag_i  (req_tag),
    .hit_o  (hit),
    .we_i   (tag_we)
  );

  // The last beat is written straight from the bus, so the line lands on its ack edge.
  always_comb begin
    for (int w = 0; w < WORDS_PER_LINE - 1; w++) begin
      line_fill[w] = fill_q[w];
    end
    line_fill[WORDS_PER_LINE-1] = i_mem_data;
  end

  always_comb begin
    state_d    = state_q;
    beat_d     = beat_q;
    ack_d      = 1'b0;
    rdata_d    = '0;
    mem_req_d  = mem_req_q;
    mem_we_d   = mem_we_q;
    mem_addr_d = mem_addr_q;
    mem_data_d = mem_data_q;
    data_d     = data_q;
    fill_d     = fill_q;
    tag_we     = 1'b0;

    case (state_q)
      StIdle: begin
        if (i_req) begin
          if (i_we) begin
            if (hit) begin
              data_d[req_index][req_off] = i_data;
            end
            mem_req_d  = 1'b1;
            mem_we_d   = 1'b1;
            mem_addr_d = {i_addr[ADDR_MEM_WIDTH-1:BYTE_OFFSET_WIDTH], 2'b00};
            mem_data_d = i_data;
            state_d    = StWrite;
          end else if (hit) begin
            ack_d   = 1'b1;
            rdata_d = data_q[req_index][req_off];
            state_d = StResp;
          end else begin
            beat_d     = '0;
            mem_req_d  = 1'b1;
            mem_we_d   = 1'b0;
            mem_addr_d = {i_addr[ADDR_MEM_WIDTH-1:LINE_LSB], 2'b00, 2'b00};
            state_d    = StRefill;
          end
        end
      end
      StRefill: begin
        if (i_mem_ack) begin
          fill_d[beat_q] = i_mem_data;
          beat_d         = beat_q + 2'd1;
          if (beat_q == 2'd3) begin
            for (int w = 0; w < WORDS_PER_LINE; w++) begin
              data_d[req_index][w] = line_fill[w];
            end
            tag_we    = 1'b1;
            mem_req_d = 1'b0;
            ack_d     = 1'b1;
            rdata_d   = line_fill[req_off];
            state_d   = StResp;
          end else begin
            mem_addr_d = {i_addr[ADDR_MEM_WIDTH-1:LINE_LSB], beat_q + 2'd1, 2'b00};
          end
        end
      end
      StWrite: begin
        if (i_mem_ack) begin
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          ack_d     = 1'b1;
          state_d   = StResp;
        end
      end
      StResp: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q    <= StIdle;
      beat_q     <= '0;
      ack_q      <= 1'b0;
      rdata_q    <= '0;
      mem_req_q  <= 1'b0;
      mem_we_q   <= 1'b0;
      mem_addr_q <= '0;
      mem_data_q <= '0;
    end else begin
      state_q    <= state_d;
      beat_q     <= beat_d;
      ack_q      <= ack_d;
      rdata_q    <= rdata_d;
      mem_req_q  <= mem_req_d;
      mem_we_q   <= mem_we_d;
      mem_addr_q <= mem_addr_d;
      mem_data_q <= mem_data_d;
    end
  end

  always_ff @(posedge i_clk) begin
    data_q <= data_d;
    fill_q <= fill_d;
  end

  assign o_ack      = ack_q;
  assign o_data     = rdata_q;
  assign o_mem_req  = mem_req_q;
  assign o_mem_we   = mem_we_q;
  assign o_mem_addr = mem_addr_q;
  assign o_mem_data = mem_data_q;

`ifdef DCACHE_PERF_EN
  logic [31:0] hit_cnt_q, hit_cnt_d;
  logic [31:0] miss_cnt_q, miss_cnt_d;
  logic        load_decide;

  assign load_decide = (state_q == StIdle) && i_req && !i_we;

  always_comb begin
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    if (load_decide && hit) begin
      hit_cnt_d = hit_cnt_q + 32'd1;
    end
    if (load_decide && !hit) begin
      miss_cnt_d = miss_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  assign o_hit_cnt  = hit_cnt_q;
  assign o_miss_cnt = miss_cnt_q;
`endif

endmodule

// File: tb/tb_dcache_ctrl.sv
// Directed self-checking bench for dcache_ctrl with a fixed-content backing memory model.
module tb_dcache_ctrl;

  logic        clk;
  logic        rst_n;
  logic        i_req;
  logic        i_we;
  logic [31:0] i_addr;
  logic [31:0] i_data;
  logic        o_ack;
  logic [31:0] o_data;
  logic        o_mem_req;
  logic        o_mem_we;
  logic [31:0] o_mem_addr;
  logic [31:0] o_mem_data;
  logic        i_mem_ack;
  logic [31:0] i_mem_data;
`ifdef DCACHE_PERF_EN
  logic [31:0] o_hit_cnt;
  logic [31:0] o_miss_cnt;
`endif

  int tests  = 0;
  int failed = 0;

  dcache_ctrl #(
    .ADDR_MEM_WIDTH(32),
    .INDEX_WIDTH   (4)
  ) dut (
    .i_clk     (clk),
    .i_rst_n   (rst_n),
    .i_req     (i_req),
    .i_we      (i_we),
    .i_addr    (i_addr),
    .i_data    (i_data),
    .o_ack     (o_ack),
    .o_data    (o_data),
    .o_mem_req (o_mem_req),
    .o_mem_we  (o_mem_we),
    .o_mem_addr(o_mem_addr),
    .o_mem_data(o_mem_data),
    .i_mem_ack (i_mem_ack),
    .i_mem_data(i_mem_data)
`ifdef DCACHE_PERF_EN
    ,
    .o_hit_cnt (o_hit_cnt),
    .o_miss_cnt(o_miss_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    case (a)
      32'h40:  return 32'h11;
      32'h44:  return 32'h22;
      32'h48:  return 32'h33;
      32'h4C:  return 32'h44;
      default: return {a[15:0], 16'hC0DE};
    endcase
  endfunction

  // Memory responder: acks once a beat has waited mem_delay cycles (0 = same cycle).
  int mem_delay = 0;
  int wait_cnt  = 0;
  assign i_mem_ack  = o_mem_req && (wait_cnt >= mem_delay);
  assign i_mem_data = mem_fn(o_mem_addr);

  always @(posedge clk) begin
    if (!o_mem_req || i_mem_ack) wait_cnt <= 0;
    else                         wait_cnt <= wait_cnt + 1;
  end

  logic [64:0] beats [$];
  int          req_cycles = 0;

  always @(posedge clk) begin
    if (o_mem_req && i_mem_ack) beats.push_back({o_mem_we, o_mem_addr, o_mem_data});
    if (o_mem_req) req_cycles <= req_cycles + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issues one request; lat = cycles from the sampling edge to the o_ack cycle (0 = timeout).
  task automatic access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        output int lat, output logic [31:0] rdata);
    bit done;
    @(negedge clk);
    beats.delete();
    req_cycles = 0;
    i_req  = 1'b1;
    i_we   = we;
    i_addr = addr;
    i_data = wdata;
    lat    = 0;
    rdata  = '0;
    done   = 1'b0;
    for (int c = 1; c <= 40 && !done; c++) begin
      @(negedge clk);
      if (o_ack) begin
        lat   = c;
        rdata = o_data;
        done  = 1'b1;
      end
    end
    i_req = 1'b0;
    i_we  = 1'b0;
  endtask

  int          lat;
  logic [31:0] rd;

  initial begin
    rst_n  = 1'b0;
    i_req  = 1'b0;
    i_we   = 1'b0;
    i_addr = '0;
    i_data = '0;
    repeat (3) @(negedge clk);
    check("rst_ack", {31'd0, o_ack}, 32'd0);
    check("rst_data", o_data, 32'd0);
    check("rst_mem_req_we", {30'd0, o_mem_req, o_mem_we}, 32'd0);
    check("rst_mem_addr", o_mem_addr, 32'd0);
    check("rst_mem_data", o_mem_data, 32'd0);
    rst_n = 1'b1;

    // Cold load miss: four in-order read beats, 5-cycle latency.
    access(1'b0, 32'h40, '0, lat, rd);
    check("miss_lat", lat, 5);
    check("miss_data", rd, 32'h11);
    check("miss_nbeats", beats.size(), 4);
    check("miss_reqcyc", req_cycles, 4);
    if (beats.size() == 4) begin
      check("miss_b0", beats[0][63:32], 32'h40);
      check("miss_b1", beats[1][63:32], 32'h44);
      check("miss_b2", beats[2][63:32], 32'h48);
      check("miss_b3", beats[3][63:32], 32'h4C);
      check("miss_b3_rd", {31'd0, beats[3][64]}, 32'd0);
    end

    access(1'b0, 32'h48, '0, lat, rd);
    check("hit_lat", lat, 1);
    check("hit_data", rd, 32'h33);
    check("hit_nbeats", beats.size(), 0);

    // Store hit with a slow memory ack.
    mem_delay = 2;
    access(1'b1, 32'h44, 32'hDEADBEEF, lat, rd);
    check("st_lat", lat, 4);
    check("st_data", rd, 32'd0);
    check("st_reqcyc", req_cycles, 3);
    check("st_nbeats", beats.size(), 1);
    if (beats.size() == 1) begin
      check("st_we", {31'd0, beats[0][64]}, 32'd1);
      check("st_addr", beats[0][63:32], 32'h44);
      check("st_wdata", beats[0][31:0], 32'hDEADBEEF);
    end
    mem_delay = 0;
    access(1'b0, 32'h44, '0, lat, rd);
    check("st_hit_lat", lat, 1);
    check("st_hit_data", rd, 32'hDEADBEEF);
    check("st_hit_nbeats", beats.size(), 0);

    // Store miss does not allocate.
    access(1'b1, 32'h1000, 32'h12345678, lat, rd);
    check("stm_lat", lat, 2);
    access(1'b0, 32'h1000, '0, lat, rd);
    check("stm_ld_lat", lat, 5);
    check("stm_ld_data", rd, 32'h1000C0DE);
    check("stm_ld_nbeats", beats.size(), 4);
    if (beats.size() == 4) begin
      check("stm_ld_b0", beats[0][63:32], 32'h1000);
      check("stm_ld_b3", beats[3][63:32], 32'h100C);
    end

    // Conflict eviction at index 4.
    access(1'b0, 32'h440, '0, lat, rd);
    check("evict_lat", lat, 5);
    check("evict_data", rd, 32'h0440C0DE);
    access(1'b0, 32'h40, '0, lat, rd);
    check("reload_lat", lat, 5);
    check("reload_data", rd, 32'h11);
    access(1'b0, 32'h4C, '0, lat, rd);
    check("reload_hit_lat", lat, 1);
    check("reload_hit_data", rd, 32'h44);

    // Reset after the second refill beat abandons the refill.
    @(negedge clk);
    beats.delete();
    i_req  = 1'b1;
    i_we   = 1'b0;
    i_addr = 32'h80;
    for (int c = 0; c < 20 && beats.size() < 2; c++) @(negedge clk);
    check("abort_beats", beats.size(), 2);
    rst_n = 1'b0;
    i_req = 1'b0;
    @(negedge clk);
    check("abort_mem_req", {31'd0, o_mem_req}, 32'd0);
    check("abort_ack", {31'd0, o_ack}, 32'd0);
    rst_n = 1'b1;
    access(1'b0, 32'h80, '0, lat, rd);
    check("abort_ld_lat", lat, 5);
    check("abort_ld_nbeats", beats.size(), 4);
    check("abort_ld_data", rd, 32'h0080C0DE);
`ifdef DCACHE_PERF_EN
    check("perf_hit", o_hit_cnt, 32'd0);
    check("perf_miss", o_miss_cnt, 32'd1);
`endif
    // Reset also invalidated the previously resident line at index 4.
    access(1'b0, 32'h48, '0, lat, rd);
    check("postrst_lat", lat, 5);
    check("postrst_data", rd, 32'h33);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
